// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the two-master data memory arbiter.
// Optional build macro: DATA_MEM_ARB_RR_EN (round-robin on contention).
package data_mem_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 6144;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        QUIESCED
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mst_idx_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Avalon-MM request/response bundle between one master and the arbiter.
// The master modport drives requests; the slave modport answers them.
interface data_mem_arbiter_if
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic                readdatavalid;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/data_mem_arb_grant.sv
// One-hot grant selection for two requesters.
// On contention the master not granted last wins.
module data_mem_arb_grant
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for a shared one-cycle-latency data memory with drain.
// Build macro DATA_MEM_ARB_RR_EN selects round-robin, else fixed priority.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    data_mem_arbiter_if.slave   m0,
    data_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                quiesce_req,
    output logic                quiesce_ack
);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    arb_state_t state, state_nxt;
    mst_idx_t   last;
    logic [1:0] req, gnt;
    logic [1:0] rdv_q, rdv_nxt;
    logic       oor_q;
    logic       run, in_range, rd_sel, wr_sel;
    logic [31:0] addr_ext;

    assign req = {m1.read | m1.write, m0.read | m0.write};
    assign run = (state == RUN);

    data_mem_arb_grant u_grant (
        .req  (req & {2{run}}),
        .last (last),
        .gnt  (gnt)
    );

    always_comb begin
        if (gnt[1]) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            rd_sel         = m1.read;
            wr_sel         = m1.write;
        end else begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
            rd_sel         = m0.read;
            wr_sel         = m0.write;
        end
    end

    assign addr_ext       = 32'(mem_address);
    assign in_range       = addr_ext < DEPTH_U;
    assign mem_chipselect = (|gnt) & in_range;
    assign mem_write      = mem_chipselect & wr_sel;
    // A read that also has write set is a write and returns nothing.
    assign rdv_nxt        = gnt & {2{rd_sel & ~wr_sel}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            rdv_q <= 2'b00;
            oor_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdv_q <= rdv_nxt;
            oor_q <= ~in_range;
        end
    end

`ifdef DATA_MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= M1;
        end else if (|gnt) begin
            last <= gnt[1] ? M1 : M0;
        end
    end
`else
    assign last = M1;
`endif

    // DRAIN issues no grants, so any return still in flight lands this cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (quiesce_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!quiesce_req)          state_nxt = RUN;
                else if (rdv_nxt == 2'b00) state_nxt = QUIESCED;
            end
            QUIESCED: begin
                if (!quiesce_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign quiesce_ack      = (state == QUIESCED);

    assign m0.waitrequest   = req[0] & ~gnt[0];
    assign m1.waitrequest   = req[1] & ~gnt[1];
    assign m0.readdatavalid = rdv_q[0];
    assign m1.readdatavalid = rdv_q[1];
    assign m0.readdata      = oor_q ? '0 : mem_readdata;
    assign m1.readdata      = oor_q ? '0 : mem_readdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and random bench for data_mem_arbiter against a transaction-level model.
// Expectations follow DATA_MEM_ARB_RR_EN when the bench is built with it.
module tb_data_mem_arbiter;

    localparam int DEPTH = 6144;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        quiesce_req;
    logic        quiesce_ack;

    data_mem_arbiter_if m0_bus ();
    data_mem_arbiter_if m1_bus ();

    data_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .quiesce_req    (quiesce_req),
        .quiesce_ack    (quiesce_ack)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: registered read, byte-masked write.
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [0:31];
    bit   [1:0]  exp_rdv;
    logic [31:0] exp_data;
    bit          blocked;
    bit          exp_ack;
    int          last_win;
    int          gcnt [2];
    int          order [$];
    bit          pin_en;
    logic [31:0] pin_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int m, input bit rd, input bit wr,
                       input logic [12:0] a, input logic [3:0] be,
                       input logic [31:0] d);
        if (m == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
            m0_bus.byteenable = be; m0_bus.writedata = d;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
            m1_bus.byteenable = be; m1_bus.writedata = d;
        end
    endtask

    task automatic idle();
        drv(0, 0, 0, '0, '0, '0);
        drv(1, 0, 0, '0, '0, '0);
    endtask

    // One clock of the reference model: pick a winner from the rules,
    // compare handshakes, then retire the transfer into the model.
    task automatic tick();
        bit          r0, r1, rd, wr, in_rng;
        int          win;
        logic [12:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        @(negedge clk);
        r0  = m0_bus.read | m0_bus.write;
        r1  = m1_bus.read | m1_bus.write;
        win = -1;
        if (!blocked) begin
            if (r0 && r1) begin
`ifdef DATA_MEM_ARB_RR_EN
                win = (last_win == 0) ? 1 : 0;
`else
                win = 0;
`endif
            end else if (r0) win = 0;
            else if (r1) win = 1;
        end
        chk("wait0", m0_bus.waitrequest, 32'(r0 && win != 0));
        chk("wait1", m1_bus.waitrequest, 32'(r1 && win != 1));
        chk("rdv0", m0_bus.readdatavalid, 32'(exp_rdv[0]));
        chk("rdv1", m1_bus.readdatavalid, 32'(exp_rdv[1]));
        if (exp_rdv[0]) chk("rdata0", m0_bus.readdata, exp_data);
        if (exp_rdv[1]) chk("rdata1", m1_bus.readdata, exp_data);
        if (pin_en) begin
            chk("pinned", exp_rdv[1] ? m1_bus.readdata : m0_bus.readdata,
                pin_data);
            pin_en = 0;
        end
        chk("ack", quiesce_ack, 32'(exp_ack));
        if (win == 1) begin
            rd = m1_bus.read; wr = m1_bus.write; a = m1_bus.address;
            be = m1_bus.byteenable; d = m1_bus.writedata;
        end else begin
            rd = m0_bus.read; wr = m0_bus.write; a = m0_bus.address;
            be = m0_bus.byteenable; d = m0_bus.writedata;
        end
        in_rng = (win >= 0) && (int'(a) < DEPTH);
        chk("cs", mem_chipselect, 32'(in_rng));
        chk("mwr", mem_write, 32'(in_rng && wr));
        exp_rdv = '0;
        if (win >= 0) begin
            last_win = win;
            gcnt[win]++;
            order.push_back(win);
            if (rd && !wr) begin
                exp_rdv[win] = 1'b1;
                exp_data = in_rng ? ref_mem[a[4:0]] : 32'h0;
            end
            if (wr && in_rng)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[4:0]][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        exp_rdv  = '0;
        last_win = 1;
        @(negedge clk);
        chk("rst_rdv0", m0_bus.readdatavalid, 0);
        chk("rst_rdv1", m1_bus.readdatavalid, 0);
        chk("rst_ack", quiesce_ack, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; quiesce_req = 1'b0;
        blocked = 0; exp_ack = 0; pin_en = 0; exp_rdv = '0;
        idle();
        #1;
        do_reset();

        // Contention for 8 cycles right after reset, out-of-range reads.
        gcnt[0] = 0; gcnt[1] = 0; order.delete();
        drv(0, 1, 0, 13'h1800, 4'hF, '0);
        drv(1, 1, 0, 13'h1801, 4'hF, '0);
        repeat (8) tick();
        idle(); tick();
`ifdef DATA_MEM_ARB_RR_EN
        chk("rr_g0", gcnt[0], 4);
        for (int i = 0; i < 8; i++) chk("rr_order", order[i], i % 2);
`else
        chk("fix_g0", gcnt[0], 8);
        chk("fix_g1", gcnt[1], 0);
`endif

        for (int i = 0; i < 32; i++) begin
            drv(0, 0, 1, 13'(i), 4'hF, $urandom);
            tick();
        end
        idle(); tick();

        // Write then cross-master read.
        drv(0, 0, 1, 13'h10, 4'hF, 32'hDEADBEEF); tick();
        idle(); drv(1, 1, 0, 13'h10, 4'hF, '0); tick();
        idle(); pin_en = 1; pin_data = 32'hDEADBEEF; tick();

        // Partial byte write.
        drv(0, 0, 1, 13'h11, 4'hF, 32'hFFFFFFFF); tick();
        drv(0, 0, 1, 13'h11, 4'h3, 32'h00001234); tick();
        drv(0, 1, 0, 13'h11, 4'hF, '0); tick();
        idle(); pin_en = 1; pin_data = 32'hFFFF1234; tick();

        // Read at DEPTH.
        drv(0, 1, 0, 13'h1800, 4'hF, '0); tick();
        idle(); pin_en = 1; pin_data = 32'h0; tick();

        // Quiesce raised in the grant cycle of a read.
        drv(0, 1, 0, 13'h5, 4'hF, '0); quiesce_req = 1; tick();
        drv(0, 1, 0, 13'h6, 4'hF, '0);
        drv(1, 1, 0, 13'h7, 4'hF, '0);
        blocked = 1; tick();
        exp_ack = 1; tick();
        tick();
        quiesce_req = 0; tick();
        exp_ack = 0; blocked = 0; tick();
        idle(); tick();

        // Quiesce withdrawn while draining.
        quiesce_req = 1; tick();
        quiesce_req = 0; blocked = 1;
        drv(1, 1, 0, 13'h8, 4'hF, '0); tick();
        blocked = 0; tick();
        idle(); tick();

        for (int n = 0; n < 300; n++) begin
            for (int m = 0; m < 2; m++) begin
                int op;
                logic [12:0] a;
                op = $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0)
                    a = ($urandom_range(0, 1) == 0) ? 13'h1800 : 13'h1FFF;
                else
                    a = 13'($urandom_range(0, 31));
                drv(m, op[0], op[1], a, 4'($urandom_range(0, 15)), $urandom);
            end
            tick();
        end
        idle(); tick();

        // Reset with a read in flight.
        drv(0, 1, 0, 13'h3, 4'hF, '0); tick();
        idle();
        do_reset();
        tick();
        drv(0, 1, 0, 13'h3, 4'hF, '0);
        drv(1, 1, 0, 13'h4, 4'hF, '0);
        gcnt[0] = 0;
        tick();
        chk("post_rst_m0", gcnt[0], 1);
        idle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
